// File: rtl/mem_host_port.sv
// Byte memory shared between a running cpu and a host byte-stream loader/monitor.
// The host owns memory while cpu_reset is high; the 'X' command hands it to the cpu until it halts.
module mem_host_port #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [7:0]            mem_data_out,
    input  logic [7:0]            mem_data_in,
    input  logic [addr_width-1:0] mem_raddr,
    input  logic [addr_width-1:0] mem_waddr,
    input  logic                  mem_write,
    output logic                  mem_ready,
    output logic                  cpu_reset,
    input  logic                  cpu_halted,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int depth = 1 << addr_width;

    typedef logic [addr_width-1:0] addr_t;
    localparam addr_t addr_one = addr_t'(1);

    localparam logic [7:0] op_write = 8'h57;
    localparam logic [7:0] op_read  = 8'h52;
    localparam logic [7:0] op_run   = 8'h58;
    localparam logic [7:0] byte_ack = 8'h06;
    localparam logic [7:0] byte_nak = 8'h15;
    localparam logic [7:0] byte_hlt = 8'h48;

    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, COUNT, WDATA, ACK,
        RADDR, RWAIT, RSEND, NAK, RUN, DONE
    } state_t;

    state_t      r_state;
    logic        r_op_write;
    logic [7:0]  r_addr_hi;
    addr_t       r_addr;
    logic [7:0]  r_count;
    logic [1:0]  r_run_cnt;
    logic        r_cpu_reset;
    logic        r_mem_ready;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_mem_data_out;
    logic [7:0]  r_host_rdata;
    logic [7:0]  r_mem [depth];

    logic        w_accepting;
    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_last;
    logic        w_host_we;
    logic        w_cpu_we;
    logic        w_we;
    addr_t       w_waddr;
    logic [7:0]  w_wdata;

    assign w_accepting = (r_state == IDLE) || (r_state == ADDR_HI) || (r_state == ADDR_LO)
                      || (r_state == COUNT) || (r_state == WDATA);
    assign rx_ready    = w_accepting && !reset;
    assign w_rx_fire   = rx_valid && rx_ready;
    assign w_tx_fire   = r_tx_valid && tx_ready;
    // A count register of 1 marks the final byte; 0 therefore decrements through 256 bytes.
    assign w_last      = (r_count == 8'd1);

    assign w_host_we = (r_state == WDATA) && w_rx_fire;
    assign w_cpu_we  = mem_write && !r_cpu_reset;
    assign w_we      = w_host_we || w_cpu_we;
    assign w_waddr   = w_host_we ? r_addr  : mem_waddr;
    assign w_wdata   = w_host_we ? rx_data : mem_data_in;

    assign mem_data_out = r_mem_data_out;
    assign mem_ready    = r_mem_ready;
    assign cpu_reset    = r_cpu_reset;
    assign tx_valid     = r_tx_valid;
    assign tx_data      = r_tx_data;

    // NOTE: RAM contents carry no reset so the array maps onto block RAM and survives a reset.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_host_rdata <= r_mem[r_addr];
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_mem_data_out <= '0;
        else
            r_mem_data_out <= r_mem[mem_raddr];
    end

    // NOTE: every register here uses non-blocking assignment so all state updates on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op_write  <= 1'b0;
            r_addr_hi   <= '0;
            r_addr      <= '0;
            r_count     <= '0;
            r_run_cnt   <= '0;
            r_cpu_reset <= 1'b1;
            r_mem_ready <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rx_fire) begin
                        if (rx_data == op_write || rx_data == op_read) begin
                            r_op_write <= (rx_data == op_write);
                            r_state    <= ADDR_HI;
                        end else if (rx_data == op_run) begin
                            r_cpu_reset <= 1'b0;
                            r_mem_ready <= 1'b1;
                            r_run_cnt   <= '0;
                            r_state     <= RUN;
                        end else begin
                            r_tx_data  <= byte_nak;
                            r_tx_valid <= 1'b1;
                            r_state    <= NAK;
                        end
                    end
                end
                ADDR_HI: begin
                    if (w_rx_fire) begin
                        r_addr_hi <= rx_data;
                        r_state   <= ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (w_rx_fire) begin
                        r_addr  <= addr_t'({r_addr_hi, rx_data});
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (w_rx_fire) begin
                        r_count <= rx_data;
                        r_state <= r_op_write ? WDATA : RADDR;
                    end
                end
                WDATA: begin
                    if (w_rx_fire) begin
                        r_addr  <= r_addr + addr_one;
                        r_count <= r_count - 8'd1;
                        if (w_last) begin
                            r_tx_data  <= byte_ack;
                            r_tx_valid <= 1'b1;
                            r_state    <= ACK;
                        end
                    end
                end
                ACK, NAK, DONE: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                RADDR: r_state <= RWAIT;
                RWAIT: begin
                    r_tx_data  <= r_host_rdata;
                    r_tx_valid <= 1'b1;
                    r_state    <= RSEND;
                end
                RSEND: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_addr     <= r_addr + addr_one;
                        r_count    <= r_count - 8'd1;
                        r_state    <= w_last ? IDLE : RADDR;
                    end
                end
                RUN: begin
                    // The cpu's halted flag is stale until it has seen its reset released.
                    if (r_run_cnt != 2'd2) begin
                        r_run_cnt <= r_run_cnt + 2'd1;
                    end else if (cpu_halted) begin
                        r_cpu_reset <= 1'b1;
                        r_mem_ready <= 1'b0;
                        r_tx_data   <= byte_hlt;
                        r_tx_valid  <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_host_port.sv
// Randomized self-checking bench for mem_host_port against a byte-array memory model.
// The bench plays both the host byte stream and a simple cpu bus master.
module tb_mem_host_port;

    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic [7:0]    mem_data_out;
    logic [7:0]    mem_data_in;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] mem_waddr;
    logic          mem_write;
    logic          mem_ready;
    logic          cpu_reset;
    logic          cpu_halted;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    mem_host_port #(.addr_width(AW)) dut (
        .clk(clk), .reset(reset),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_write(mem_write),
        .mem_ready(mem_ready), .cpu_reset(cpu_reset), .cpu_halted(cpu_halted),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] model [DEPTH];
    bit         known [DEPTH];
    logic [7:0] wq [$];

    task automatic host_send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_accept: byte %h rx_ready=%b required 1", b, rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic host_recv(output logic [7:0] b, input bit stall);
        int n = 0;
        logic [7:0] held;
        tx_ready = 1'b0;
        while (tx_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL tx_timeout: tx_valid=%b required 1", tx_valid);
            b = 8'hxx;
            return;
        end
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_ready_during_tx: got %b required 0", rx_ready);
        end
        if (stall) begin
            held = tx_data;
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
                errors++;
                $display("FAIL tx_hold: valid=%b data=%h required 1/%h", tx_valid, tx_data, held);
            end
        end
        b = tx_data;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a16, input logic [7:0] cnt);
        int n = (cnt == 8'd0) ? 256 : int'(cnt);
        int a;
        logic [7:0] b;
        host_send(8'h57);
        host_send(a16[15:8]);
        host_send(a16[7:0]);
        host_send(cnt);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                checks++;
                if (tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_ack: tx_valid=%b before last byte, required 0", tx_valid);
                end
            end
            host_send(wq[i]);
            a = (int'(a16) + i) % DEPTH;
            model[a] = wq[i];
            known[a] = 1'b1;
        end
        host_recv(b, 1'b0);
        checks++;
        if (b !== 8'h06) begin
            errors++;
            $display("FAIL write_ack: got %h required 06", b);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_once: tx_valid=%b after ack, required 0", tx_valid);
        end
    endtask

    task automatic do_read(input logic [15:0] a16, input logic [7:0] cnt, input bit alt);
        int n = (cnt == 8'd0) ? 256 : int'(cnt);
        int a;
        logic [7:0] b;
        host_send(8'h52);
        host_send(a16[15:8]);
        host_send(a16[7:0]);
        host_send(cnt);
        for (int i = 0; i < n; i++) begin
            host_recv(b, alt ? bit'(i % 2) : bit'($urandom_range(0, 1)));
            a = (int'(a16) + i) % DEPTH;
            if (known[a]) begin
                checks++;
                if (b !== model[a]) begin
                    errors++;
                    $display("FAIL read_data: addr %h got %h required %h", a, b, model[a]);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_no_ack: tx_valid=%b rx_ready=%b required 0/1", tx_valid, rx_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_reset, mem_ready, tx_valid, rx_ready} !== 4'b1000 || tx_data !== 8'h00
            || mem_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: cr/mr/tv/rr=%b%b%b%b tx=%h mdo=%h required 1000/00/00",
                     cpu_reset, mem_ready, tx_valid, rx_ready, tx_data, mem_data_out);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_rx_ready: got %b required 1", rx_ready);
        end
    endtask

    task automatic test_write_read();
        wq = '{8'hAA, 8'hBB, 8'hCC};
        do_write(16'h0010, 8'd3);
        do_read(16'h0010, 8'd3, 1'b1);
    endtask

    task automatic test_wrap_and_count0();
        wq = '{8'h11, 8'h22};
        do_write(16'h01FF, 8'd2);
        do_read(16'h01FF, 8'd2, 1'b0);
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(8'($urandom));
        do_write(16'h0120, 8'd0);
        do_read(16'h0120, 8'd0, 1'b0);
    endtask

    task automatic test_random_transfers();
        logic [15:0] a16;
        logic [7:0]  cnt;
        for (int t = 0; t < 4; t++) begin
            a16 = 16'($urandom);
            cnt = 8'($urandom_range(1, 12));
            wq.delete();
            for (int i = 0; i < int'(cnt); i++) wq.push_back(8'($urandom));
            do_write(a16, cnt);
            do_read(a16, cnt, 1'b0);
        end
    endtask

    task automatic test_nak_and_protect();
        logic [7:0] b;
        host_send(8'h41);
        host_recv(b, 1'b1);
        checks++;
        if (b !== 8'h15) begin
            errors++;
            $display("FAIL nak_byte: got %h required 15", b);
        end
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL nak_idle: rx_ready=%b tx_valid=%b required 1/0", rx_ready, tx_valid);
        end
        mem_waddr   = 9'h010;
        mem_data_in = ~model[16];
        mem_write   = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        mem_raddr = 9'h010;
        @(negedge clk);
        checks++;
        if (mem_data_out !== model[16]) begin
            errors++;
            $display("FAIL cpu_write_blocked: got %h required %h", mem_data_out, model[16]);
        end
    endtask

    task automatic test_run();
        logic [7:0] b;
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(8'($urandom_range(0, 254)));
        wq.push_back(8'hFF);
        wq.push_back(8'hFF);
        do_write(16'h0100, 8'd8);
        cpu_halted = 1'b1;
        host_send(8'h58);
        checks++;
        if (cpu_reset !== 1'b0 || mem_ready !== 1'b1 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_start: cr=%b mr=%b rr=%b required 0/1/0", cpu_reset, mem_ready, rx_ready);
        end
        repeat (2) @(negedge clk);
        cpu_halted = 1'b0;
        checks++;
        if (cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL halt_ignore: cpu_reset=%b required 0", cpu_reset);
        end
        for (int i = 0; i < 8; i++) begin
            mem_raddr = AW'(9'h100 + i);
            @(negedge clk);
            checks++;
            if (mem_data_out !== model[256 + i]) begin
                errors++;
                $display("FAIL cpu_fetch: addr %h got %h required %h", 256 + i, mem_data_out, model[256 + i]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            mem_waddr   = AW'(2 + i);
            mem_data_in = 8'($urandom);
            mem_write   = 1'b1;
            model[2 + i] = mem_data_in;
            known[2 + i] = 1'b1;
            @(negedge clk);
        end
        mem_write = 1'b0;
        checks++;
        if (cpu_reset !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_hold: cr=%b rr=%b required 0/0", cpu_reset, rx_ready);
        end
        cpu_halted = 1'b1;
        host_recv(b, 1'b1);
        checks++;
        if (b !== 8'h48 || cpu_reset !== 1'b1 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_done: tx=%h cr=%b mr=%b required 48/1/0", b, cpu_reset, mem_ready);
        end
        do_read(16'h0002, 8'h40, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [7:0] d0, d1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        host_send(8'h57);
        host_send(8'h00);
        host_send(8'h30);
        host_send(8'h04);
        host_send(d0);
        host_send(d1);
        model[48] = d0; known[48] = 1'b1;
        model[49] = d1; known[49] = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_wdata: cr=%b tv=%b required 1/0", cpu_reset, tx_valid);
        end
        @(negedge clk);
        do_read(16'h0030, 8'd2, 1'b0);
        cpu_halted = 1'b0;
        host_send(8'h58);
        repeat (4) @(negedge clk);
        checks++;
        if (cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL rerun: cpu_reset=%b required 0", cpu_reset);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (cpu_reset !== 1'b1 || mem_ready !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_run: cr=%b mr=%b tv=%b required 1/0/0", cpu_reset, mem_ready, tx_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: tv=%b rr=%b required 0/1", tx_valid, rx_ready);
        end
        cpu_halted = 1'b1;
        do_read(16'h0010, 8'd3, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tx_ready    = 1'b0;
        mem_write   = 1'b0;
        mem_waddr   = '0;
        mem_raddr   = '0;
        mem_data_in = 8'h00;
        cpu_halted  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 8'h00;
            known[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_wrap_and_count0();
        test_random_transfers();
        test_nak_and_protect();
        test_run();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_host_port.md
Name: mem_host_port

Overview:
- Memory responder for the cpu byte memory interface: 2^addr_width bytes of block RAM serving the cpu's registered-address read and write accesses.
- Second owner is a host byte stream (rx/tx valid/ready, fed by the UART front end) that loads programs, reads memory back (including the halt register dump) and starts the cpu.
- Owns cpu_reset: the host owns memory while the cpu is held in reset; the cpu owns memory while it runs.

Parameters:
- addr_width, 9, address bits; memory depth 2^addr_width bytes.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- mem_data_out  output  8  read data to cpu; registered, one cycle after mem_raddr
- mem_data_in  input  8  write data from cpu
- mem_raddr  input  addr_width  cpu read address
- mem_waddr  input  addr_width  cpu write address
- mem_write  input  1  cpu write strobe; one byte per cycle high
- mem_ready  output  1  high while the cpu owns memory
- cpu_reset  output  1  drives the cpu reset input
- cpu_halted  input  1  cpu halted flag
- rx_data  input  8  host command/data byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  byte accepted on a cycle where rx_valid and rx_ready are both high
- tx_data  output  8  response byte
- tx_valid  output  1  tx_data valid; held with tx_data stable until tx_ready
- tx_ready  input  1  host accepts tx_data

Behaviour:
- Reset values: cpu_reset=1, mem_ready=0, mem_data_out=0, tx_valid=0, tx_data=0, rx_ready=0 on the reset cycle; state IDLE.
- Memory contents are not cleared by reset; a reset mid-command aborts to IDLE and preserves memory.
- Ownership:
  - cpu_reset=1: host owns memory. CPU mem_write is ignored. mem_data_out still tracks mem_raddr.
  - cpu_reset=0: cpu owns memory. mem_ready=1.
- Read port: data registered each clk from RAM[owner address], giving 1-cycle latency; the cpu samples 2 cycles after setting mem_raddr.
- Write port: cpu write when mem_write & !cpu_reset; host write in WDATA; the two never coincide.
- Addresses:
  - Host address = {addr_hi, addr_lo} truncated to addr_width bits.
  - The address increments per byte and wraps from 2^addr_width-1 to 0.
- Byte count: 8 bits; 0 means 256.
- rx_ready=1 only in IDLE, ADDR_HI, ADDR_LO, COUNT and WDATA.
- FSM states and transitions:
  - IDLE:
    - 0x57 'W' or 0x52 'R': latch the opcode, go to ADDR_HI.
    - 0x58 'X': go to RUN.
    - Any other byte: go to NAK.
  - ADDR_HI, then ADDR_LO, then COUNT; each takes one accepted byte. After COUNT go to WDATA ('W') or RADDR ('R').
  - WDATA: each accepted byte writes RAM[addr], then addr+1 and count-1. After the last byte go to ACK.
  - ACK: tx_data=0x06, tx_valid=1 until tx_ready, then IDLE.
  - RADDR: present addr to RAM, go to RWAIT.
  - RWAIT: one cycle, then latch the byte into tx_data, go to RSEND.
  - RSEND:
    - Hold tx_valid until tx_ready.
    - On the handshake, addr+1 and count-1.
    - Last byte: go to IDLE, with no ACK sent after the read.
    - Otherwise go to RADDR.
  - NAK: tx_data=0x15, hold until tx_ready, then IDLE.
  - RUN:
    - cpu_reset=0.
    - cpu_halted is ignored for the first 2 cycles, because halted clears one cycle after cpu reset falls.
    - Afterwards, cpu_halted=1 sets cpu_reset=1 and goes to DONE.
    - rx bytes are not accepted.
    - No timeout.
  - DONE: tx_data=0x48 'H', hold until tx_ready, then IDLE.
- After 'H', the register dump at bytes 2..65 is readable with an 'R' command.
- tx_valid never drops without a handshake except on reset.

Test Plan:
- Reset, then 'W' 00 10 03 AA BB CC -> RAM[0x10..0x12]=AA,BB,CC; tx 0x06 once; rx_ready high only in accepting states.
- After the previous step, 'R' 00 10 03 with tx_ready toggling 1-0-1 -> tx exactly AA,BB,CC; tx_data stable while tx_valid & !tx_ready; no ACK.
- 'W' 01 FF 02 11 22 (addr_width=9) -> RAM[0x1FF]=11, RAM[0x000]=22; count 00 -> 256 bytes accepted before ACK.
- Load a program ending in FFFF, send 'X' -> cpu_reset falls, mem_ready=1; cpu fetches see the 1-cycle read data; halted -> cpu_reset=1, tx 0x48; 'R' 00 02 40 returns the register dump.
- rx 0x41 in IDLE -> tx 0x15, return to IDLE; cpu mem_write asserted while cpu_reset=1 -> RAM unchanged.
- Assert reset mid-WDATA and mid-RUN -> IDLE, cpu_reset=1, tx_valid=0; previously written bytes intact on read-back.
